// File: rtl/mem_stage_if.sv
// Load/store bus between the MEM stage (master) and the data memory (slave).
// The request, address and write data are held stable until bus_rdy is seen.
interface mem_stage_if;
  logic        bus_req;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wr_data;
  logic        bus_rdy;
  logic [31:0] bus_rd_data;

  modport master (
    output bus_req, bus_rw, bus_addr, bus_be, bus_wr_data,
    input  bus_rdy, bus_rd_data
  );

  modport slave (
    input  bus_req, bus_rw, bus_addr, bus_be, bus_wr_data,
    output bus_rdy, bus_rd_data
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes the EX/MEM memory op, runs the load/store bus
// transaction, aligns load data and drives the MEM/WB pipeline register.
module mem_stage #(
  parameter logic [2:0] EXP_MISALIGN = 3'd3,
  parameter logic [2:0] EXP_NO_EXP   = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  mem_stage_if.master bus,
  output logic        busy,
  output logic [31:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        is_load_s, is_store_s, misalign_s, access_s;
  logic        req_s, busy_s;
  logic [3:0]  be_s;
  logic [31:0] wr_data_s, load_data_s;

  logic [31:0] mem_pc_q, mem_pc_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_br_flag_q, mem_br_flag_d;
  logic [1:0]  mem_ctrl_op_q, mem_ctrl_op_d;
  logic [4:0]  mem_dst_addr_q, mem_dst_addr_d;
  logic        mem_gpr_we_q, mem_gpr_we_d;
  logic [2:0]  mem_exp_code_q, mem_exp_code_d;
  logic [31:0] mem_out_q, mem_out_d;

  // Little-endian lane selection plus sign/zero extension of the read word.
  function automatic logic [31:0] align_load(input logic [3:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] rd);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = lane[1] ? rd[31:16] : rd[15:0];
    case (lane)
      2'd0:    byte_v = rd[7:0];
      2'd1:    byte_v = rd[15:8];
      2'd2:    byte_v = rd[23:16];
      default: byte_v = rd[31:24];
    endcase
    case (op)
      OP_LH:   align_load = {{16{half_v[15]}}, half_v};
      OP_LHU:  align_load = {16'h0000, half_v};
      OP_LB:   align_load = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  align_load = {24'h00_0000, byte_v};
      default: align_load = rd;
    endcase
  endfunction

  // Op decode and alignment check.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    misalign_s = 1'b0;
    case (ex_mem_op)
      OP_LW:         begin is_load_s  = 1'b1; misalign_s = (ex_out[1:0] != 2'b00); end
      OP_LH, OP_LHU: begin is_load_s  = 1'b1; misalign_s = ex_out[0]; end
      OP_LB, OP_LBU: begin is_load_s  = 1'b1; end
      OP_SW:         begin is_store_s = 1'b1; misalign_s = (ex_out[1:0] != 2'b00); end
      OP_SH:         begin is_store_s = 1'b1; misalign_s = ex_out[0]; end
      OP_SB:         begin is_store_s = 1'b1; end
      default:       begin is_load_s  = 1'b0; is_store_s = 1'b0; misalign_s = 1'b0; end
    endcase
    access_s = ex_en & (is_load_s | is_store_s) & (ex_exp_code == EXP_NO_EXP) & ~misalign_s;
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_s      = 4'b1111;
    wr_data_s = ex_mem_wr_data;
    case (ex_mem_op)
      OP_SH: begin
        be_s      = ex_out[1] ? 4'b1100 : 4'b0011;
        wr_data_s = {2{ex_mem_wr_data[15:0]}};
      end
      OP_SB: begin
        be_s      = 4'b0001 << ex_out[1:0];
        wr_data_s = {4{ex_mem_wr_data[7:0]}};
      end
      default: begin
        be_s      = 4'b1111;
        wr_data_s = ex_mem_wr_data;
      end
    endcase
  end

  // Bus-master FSM next state; WAIT relies on upstream holding ex_* while busy.
  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    busy_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          req_s = 1'b1;
          if (bus.bus_rdy) begin
            busy_s  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            busy_s  = 1'b1;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (bus.bus_rdy) begin
          busy_s  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_s  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset gating keeps the request quiet even if ex_* still presents an access.
  assign bus.bus_req     = req_s & ~reset;
  assign busy            = busy_s & ~reset;
  assign bus.bus_rw      = is_store_s;
  assign bus.bus_addr    = {ex_out[31:2], 2'b00};
  assign bus.bus_be      = be_s;
  assign bus.bus_wr_data = wr_data_s;
  assign load_data_s     = align_load(ex_mem_op, ex_out[1:0], bus.bus_rd_data);

  // MEM/WB next value: stall holds, flush clears, misalign raises an exception.
  always_comb begin
    mem_pc_d       = mem_pc_q;
    mem_en_d       = mem_en_q;
    mem_br_flag_d  = mem_br_flag_q;
    mem_ctrl_op_d  = mem_ctrl_op_q;
    mem_dst_addr_d = mem_dst_addr_q;
    mem_gpr_we_d   = mem_gpr_we_q;
    mem_exp_code_d = mem_exp_code_q;
    mem_out_d      = mem_out_q;
    if (stall) begin
      mem_pc_d = mem_pc_q;
    end else if (flush) begin
      mem_pc_d       = 32'h0000_0000;
      mem_en_d       = 1'b0;
      mem_br_flag_d  = 1'b0;
      mem_ctrl_op_d  = 2'b00;
      mem_dst_addr_d = 5'd0;
      mem_gpr_we_d   = 1'b1;
      mem_exp_code_d = EXP_NO_EXP;
      mem_out_d      = 32'h0000_0000;
    end else if (misalign_s & ex_en & (ex_exp_code == EXP_NO_EXP)) begin
      mem_pc_d       = ex_pc;
      mem_en_d       = ex_en;
      mem_br_flag_d  = ex_br_flag;
      mem_ctrl_op_d  = 2'b00;
      mem_dst_addr_d = 5'd0;
      mem_gpr_we_d   = 1'b1;
      mem_exp_code_d = EXP_MISALIGN;
      mem_out_d      = 32'h0000_0000;
    end else begin
      mem_pc_d       = ex_pc;
      mem_en_d       = ex_en;
      mem_br_flag_d  = ex_br_flag;
      mem_ctrl_op_d  = ex_ctrl_op;
      mem_dst_addr_d = ex_dst_addr;
      mem_gpr_we_d   = ex_gpr_we_;
      mem_exp_code_d = ex_exp_code;
      mem_out_d      = is_load_s ? load_data_s : ex_out;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pc_q       <= 32'h0000_0000;
      mem_en_q       <= 1'b0;
      mem_br_flag_q  <= 1'b0;
      mem_ctrl_op_q  <= 2'b00;
      mem_dst_addr_q <= 5'd0;
      mem_gpr_we_q   <= 1'b1;
      mem_exp_code_q <= EXP_NO_EXP;
      mem_out_q      <= 32'h0000_0000;
    end else begin
      mem_pc_q       <= mem_pc_d;
      mem_en_q       <= mem_en_d;
      mem_br_flag_q  <= mem_br_flag_d;
      mem_ctrl_op_q  <= mem_ctrl_op_d;
      mem_dst_addr_q <= mem_dst_addr_d;
      mem_gpr_we_q   <= mem_gpr_we_d;
      mem_exp_code_q <= mem_exp_code_d;
      mem_out_q      <= mem_out_d;
    end
  end

  assign mem_pc       = mem_pc_q;
  assign mem_en       = mem_en_q;
  assign mem_br_flag  = mem_br_flag_q;
  assign mem_ctrl_op  = mem_ctrl_op_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_exp_code = mem_exp_code_q;
  assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions against an arithmetic reference model of the stage.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset, stall_extra, flush, stall;
  logic [31:0] ex_pc, ex_mem_wr_data, ex_out;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [3:0]  ex_mem_op;
  logic [1:0]  ex_ctrl_op;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic        busy, mem_en, mem_br_flag, mem_gpr_we_;
  logic [31:0] mem_pc, mem_out;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;

  int total = 0;
  int bad   = 0;

  mem_stage_if bus_if ();

  // The pipeline controller stalls upstream whenever the stage is busy.
  assign stall = stall_extra | busy;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus(bus_if), .busy(busy),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd6:       return 4;
      4'd2, 4'd3, 4'd7: return 2;
      4'd4, 4'd5, 4'd8: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit ref_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit ref_misalign(input logic [3:0] op, input logic [31:0] addr);
    int sz = ref_size(op);
    return (sz > 0) && ((addr % sz) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
    int sz = ref_size(op);
    if (ref_store(op)) return 4'(((1 << sz) - 1) << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op)
      4'd7:    return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      4'd8:    return (wd & 32'h0000_00FF) * 32'h0101_0101;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    longint v;
    int     sh;
    case (op)
      4'd2, 4'd3: begin
        sh = addr[1] ? 16 : 0;
        v  = longint'((rd >> sh) & 32'h0000_FFFF);
        if (op == 4'd2 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      4'd4, 4'd5: begin
        sh = 8 * int'(addr % 4);
        v  = longint'((rd >> sh) & 32'h0000_00FF);
        if (op == 4'd4 && v >= 128) v = v - 256;
        return 32'(v);
      end
      default: return rd;
    endcase
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  logic [31:0] cur_pc;
  logic        cur_br;
  logic [4:0]  cur_dst;
  logic [1:0]  cur_ctrl;

  task automatic set_ex(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] exp);
    ex_en          = 1'b1;
    ex_mem_op      = op;
    ex_out         = addr;
    ex_mem_wr_data = wd;
    ex_exp_code    = exp;
    ex_pc          = $urandom;
    ex_br_flag     = 1'($urandom);
    ex_ctrl_op     = 2'($urandom);
    ex_dst_addr    = 5'($urandom_range(1, 31));
    ex_gpr_we_     = ref_store(op);
    cur_pc = ex_pc; cur_br = ex_br_flag; cur_dst = ex_dst_addr; cur_ctrl = ex_ctrl_op;
  endtask

  task automatic prime(input logic [31:0] pc);
    @(negedge clk);
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_pc = pc; ex_out = ~pc; ex_exp_code = 3'd0;
    ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd7; ex_ctrl_op = 2'd2; ex_br_flag = 1'b1;
    flush = 1'b0; stall_extra = 1'b0; bus_if.bus_rdy = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall_extra = 1'b0;
    ex_en = 1'b0; ex_mem_op = 4'd0; ex_pc = 32'h0; ex_out = 32'h0; ex_mem_wr_data = 32'h0;
    ex_br_flag = 1'b0; ex_ctrl_op = 2'd0; ex_dst_addr = 5'd0; ex_gpr_we_ = 1'b1; ex_exp_code = 3'd0;
    bus_if.bus_rdy = 1'b0; bus_if.bus_rd_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out}
        !== {32'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0}) begin
      bad++; $display("FAIL reset_regs: got pc=%h en=%b we_=%b exp=%0d out=%h, want zeros/we_=1",
                      mem_pc, mem_en, mem_gpr_we_, mem_exp_code, mem_out);
    end
    total++;
    if ({bus_if.bus_req, busy} !== 2'b00) begin
      bad++; $display("FAIL reset_bus: got req=%b busy=%b want 0 0", bus_if.bus_req, busy);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_lw_fast();
    @(negedge clk);
    set_ex(4'd1, 32'h0000_0100, 32'h0, 3'd0);
    bus_if.bus_rdy = 1'b1; bus_if.bus_rd_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({bus_if.bus_req, bus_if.bus_rw, bus_if.bus_be, bus_if.bus_addr, busy}
        !== {1'b1, 1'b0, 4'b1111, 32'h0000_0100, 1'b0}) begin
      bad++; $display("FAIL lw_fast_bus: got req=%b rw=%b be=%b addr=%h busy=%b want 1 0 1111 00000100 0",
                      bus_if.bus_req, bus_if.bus_rw, bus_if.bus_be, bus_if.bus_addr, busy);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_out, mem_en, mem_pc} !== {32'hDEAD_BEEF, 1'b1, cur_pc}) begin
      bad++; $display("FAIL lw_fast_wb: got out=%h en=%b pc=%h want deadbeef 1 %h",
                      mem_out, mem_en, mem_pc, cur_pc);
    end
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops  [3] = '{4'd4, 4'd5, 4'd3};
    logic [31:0] adrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_ex(ops[i], adrs[i], 32'h0, 3'd0);
      bus_if.bus_rdy = 1'b1; bus_if.bus_rd_data = 32'h8011_2233;
      @(posedge clk); #1;
      total++;
      if (mem_out !== want[i]) begin
        bad++; $display("FAIL load_ext_%0d: got %h want %h", i, mem_out, want[i]);
      end
    end
  endtask

  task automatic test_sb_wait();
    prime(32'h0000_1111);
    @(negedge clk);
    set_ex(4'd8, 32'h0000_0201, 32'h0000_00A5, 3'd0);
    bus_if.bus_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus_if.bus_req, bus_if.bus_rw, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wr_data, busy}
          !== {1'b1, 1'b1, 4'b0010, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1}) begin
        bad++; $display("FAIL sb_wait_bus_%0d: got req=%b rw=%b be=%b addr=%h wd=%h busy=%b",
                        i, bus_if.bus_req, bus_if.bus_rw, bus_if.bus_be, bus_if.bus_addr,
                        bus_if.bus_wr_data, busy);
      end
      @(posedge clk); #1;
      total++;
      if ({mem_pc, mem_out} !== {32'h0000_1111, ~32'h0000_1111}) begin
        bad++; $display("FAIL sb_wait_hold_%0d: got pc=%h out=%h want 00001111 ffffeeee", i, mem_pc, mem_out);
      end
      @(negedge clk);
    end
    bus_if.bus_rdy = 1'b1;
    #1;
    total++;
    if ({bus_if.bus_req, busy, bus_if.bus_be} !== {1'b1, 1'b0, 4'b0010}) begin
      bad++; $display("FAIL sb_wait_done: got req=%b busy=%b be=%b want 1 0 0010",
                      bus_if.bus_req, busy, bus_if.bus_be);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_out, mem_en, mem_gpr_we_, mem_exp_code, mem_pc} !== {32'h0000_0201, 1'b1, 1'b1, 3'd0, cur_pc}) begin
      bad++; $display("FAIL sb_wait_wb: got out=%h en=%b we_=%b exp=%0d pc=%h",
                      mem_out, mem_en, mem_gpr_we_, mem_exp_code, mem_pc);
    end
    @(negedge clk); bus_if.bus_rdy = 1'b0; ex_en = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL sb_wait_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  ops  [3] = '{4'd1, 4'd7, 4'd6};
    logic [31:0] adrs [3] = '{32'h102, 32'h0FF, 32'h101};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_ex(ops[i], adrs[i], 32'h1234_5678, 3'd0);
      ex_gpr_we_ = 1'b0;
      bus_if.bus_rdy = 1'b1;
      #1;
      total++;
      if (bus_if.bus_req !== 1'b0) begin
        bad++; $display("FAIL misalign_req_%0d: got %b want 0", i, bus_if.bus_req);
      end
      @(posedge clk); #1;
      total++;
      if ({mem_exp_code, mem_gpr_we_, mem_pc, mem_out, mem_dst_addr, mem_ctrl_op, mem_en, mem_br_flag}
          !== {3'd3, 1'b1, cur_pc, 32'h0, 5'd0, 2'd0, 1'b1, cur_br}) begin
        bad++; $display("FAIL misalign_wb_%0d: got exp=%0d we_=%b pc=%h out=%h dst=%0d want 3 1 %h 0 0",
                        i, mem_exp_code, mem_gpr_we_, mem_pc, mem_out, mem_dst_addr, cur_pc);
      end
    end
  endtask

  task automatic test_flush_wait();
    prime(32'h0000_2222);
    @(negedge clk);
    set_ex(4'd1, 32'h0000_0300, 32'h0, 3'd0);
    bus_if.bus_rdy = 1'b0; bus_if.bus_rd_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    #1;
    total++;
    if ({bus_if.bus_req, busy} !== 2'b11) begin
      bad++; $display("FAIL flush_wait_bus: got req=%b busy=%b want 1 1", bus_if.bus_req, busy);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_en, mem_pc} !== {1'b1, 32'h0000_2222}) begin
      bad++; $display("FAIL flush_wait_hold: got en=%b pc=%h want 1 00002222", mem_en, mem_pc);
    end
    @(negedge clk); bus_if.bus_rdy = 1'b1;
    #1;
    total++;
    if ({bus_if.bus_req, busy} !== 2'b10) begin
      bad++; $display("FAIL flush_wait_done: got req=%b busy=%b want 1 0", bus_if.bus_req, busy);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out}
        !== {32'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0}) begin
      bad++; $display("FAIL flush_wait_clear: got pc=%h en=%b we_=%b out=%h want cleared",
                      mem_pc, mem_en, mem_gpr_we_, mem_out);
    end
    @(negedge clk); flush = 1'b0; bus_if.bus_rdy = 1'b0; ex_en = 1'b0;
    #1;
    total++;
    if ({bus_if.bus_req, busy} !== 2'b00) begin
      bad++; $display("FAIL flush_wait_idle: got req=%b busy=%b want 0 0", bus_if.bus_req, busy);
    end
  endtask

  task automatic test_reset_wait();
    prime(32'h0000_3333);
    @(negedge clk);
    set_ex(4'd6, 32'h0000_0400, 32'hCAFE_F00D, 3'd0);
    bus_if.bus_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({bus_if.bus_req, busy, mem_pc, mem_en, mem_gpr_we_, mem_exp_code, mem_out, mem_dst_addr}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 32'h0, 5'd0}) begin
      bad++; $display("FAIL reset_wait: got req=%b busy=%b pc=%h en=%b we_=%b out=%h want reset values",
                      bus_if.bus_req, busy, mem_pc, mem_en, mem_gpr_we_, mem_out);
    end
    @(negedge clk); ex_en = 1'b0; reset = 1'b0;
    #1;
    total++;
    if ({bus_if.bus_req, busy} !== 2'b00) begin
      bad++; $display("FAIL reset_wait_idle: got req=%b busy=%b want 0 0", bus_if.bus_req, busy);
    end
  endtask

  task automatic test_exception_stall();
    logic [31:0] pc_w;
    logic [4:0]  dst_w;
    @(negedge clk);
    set_ex(4'd1, 32'h0000_0500, 32'h0, 3'd1);
    bus_if.bus_rdy = 1'b1;
    #1;
    total++;
    if (bus_if.bus_req !== 1'b0) begin
      bad++; $display("FAIL exc_req: got %b want 0", bus_if.bus_req);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_exp_code, mem_en, mem_pc, mem_dst_addr} !== {3'd1, 1'b1, cur_pc, cur_dst}) begin
      bad++; $display("FAIL exc_wb: got exp=%0d en=%b pc=%h want 1 1 %h", mem_exp_code, mem_en, mem_pc, cur_pc);
    end
    pc_w = cur_pc; dst_w = cur_dst;
    @(negedge clk);
    stall_extra = 1'b1;
    set_ex(4'd0, 32'h0000_0600, 32'h0, 3'd2);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({mem_exp_code, mem_en, mem_pc, mem_dst_addr} !== {3'd1, 1'b1, pc_w, dst_w}) begin
        bad++; $display("FAIL stall_hold_%0d: got exp=%0d pc=%h dst=%0d want 1 %h %0d",
                        i, mem_exp_code, mem_pc, mem_dst_addr, pc_w, dst_w);
      end
    end
    @(negedge clk); stall_extra = 1'b0; ex_en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr, rd, e_pc, e_out;
    logic [2:0]  e_exp;
    logic [4:0]  e_dst;
    logic [1:0]  e_ctrl;
    logic        e_en, e_br, e_we, acc, mis, chk_out;
    int          waits;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      op   = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      set_ex(op, addr, $urandom, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      ex_en      = ($urandom_range(0, 9) != 0);
      ex_gpr_we_ = 1'($urandom);
      flush      = ($urandom_range(0, 9) == 0);
      waits      = $urandom_range(0, 3);
      rd         = $urandom;
      bus_if.bus_rd_data = rd;
      bus_if.bus_rdy     = (waits == 0);
      mis = ref_misalign(op, addr);
      acc = ex_en && ref_size(op) > 0 && ex_exp_code == 3'd0 && !mis;
      #1;
      total++;
      if (bus_if.bus_req !== acc) begin
        bad++; $display("FAIL rnd_req_%0d: op=%0d addr=%h got %b want %b", n, op, addr, bus_if.bus_req, acc);
      end
      if (acc) begin
        total++;
        if ({bus_if.bus_addr, bus_if.bus_be, bus_if.bus_rw, busy}
            !== {addr & 32'hFFFF_FFFC, ref_be(op, addr), 1'(ref_store(op)), 1'(waits != 0)}) begin
          bad++; $display("FAIL rnd_bus_%0d: op=%0d addr=%h got a=%h be=%b rw=%b busy=%b",
                          n, op, addr, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_rw, busy);
        end
        if (ref_store(op)) begin
          total++;
          if (bus_if.bus_wr_data !== ref_wdata(op, ex_mem_wr_data)) begin
            bad++; $display("FAIL rnd_wdata_%0d: got %h want %h", n, bus_if.bus_wr_data,
                            ref_wdata(op, ex_mem_wr_data));
          end
        end
        for (int k = 1; k <= waits; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (k == waits) bus_if.bus_rdy = 1'b1;
          #1;
          total++;
          if ({bus_if.bus_req, busy} !== {1'b1, 1'(k != waits)}) begin
            bad++; $display("FAIL rnd_wait_%0d_%0d: got req=%b busy=%b", n, k, bus_if.bus_req, busy);
          end
        end
      end
      chk_out = 1'b1;
      if (flush) begin
        e_pc = 32'h0; e_en = 1'b0; e_br = 1'b0; e_ctrl = 2'd0; e_dst = 5'd0;
        e_we = 1'b1; e_exp = 3'd0; e_out = 32'h0;
      end else if (mis && ex_en && ex_exp_code == 3'd0) begin
        e_pc = cur_pc; e_en = 1'b1; e_br = cur_br; e_ctrl = 2'd0; e_dst = 5'd0;
        e_we = 1'b1; e_exp = 3'd3; e_out = 32'h0;
      end else begin
        e_pc = cur_pc; e_en = ex_en; e_br = cur_br; e_ctrl = cur_ctrl; e_dst = cur_dst;
        e_we = ex_gpr_we_; e_exp = ex_exp_code;
        if (op >= 4'd1 && op <= 4'd5) begin
          e_out   = ref_load(op, addr, rd);
          chk_out = acc;
        end else begin
          e_out = addr;
        end
      end
      @(posedge clk); #1;
      total++;
      if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code}
          !== {e_pc, e_en, e_br, e_ctrl, e_dst, e_we, e_exp}) begin
        bad++; $display("FAIL rnd_wb_%0d: op=%0d got pc=%h en=%b dst=%0d we_=%b exp=%0d want %h %b %0d %b %0d",
                        n, op, mem_pc, mem_en, mem_dst_addr, mem_gpr_we_, mem_exp_code,
                        e_pc, e_en, e_dst, e_we, e_exp);
      end
      if (chk_out) begin
        total++;
        if (mem_out !== e_out) begin
          bad++; $display("FAIL rnd_out_%0d: op=%0d addr=%h rd=%h got %h want %h",
                          n, op, addr, rd, mem_out, e_out);
        end
      end
    end
    @(negedge clk); flush = 1'b0; ex_en = 1'b0; bus_if.bus_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_load_ext();
    test_sb_wait();
    test_misalign();
    test_flush_wait();
    test_reset_wait();
    test_exception_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
